siren_controller: RTL and testbench
===================================

// Module: siren_controller
// PURPOSE
//  Downstream consumer of the window module's alarm output (walm) in the smart-home chain.
//  Holds the arm/disarm state and latches intrusions.
//  Drives the siren for a bounded time and accepts a 4-bit passcode to disarm.
//  Locks out code entry after repeated wrong codes. Single clock domain, same clk as window.
// PARAMETERS
//  SIREN_CYCLES    20    cycles siren stays high per trigger/retrigger (>=1)
//  LOCKOUT_CYCLES  30    cycles siren is forced high and codes are ignored after MAX_TRIES wrong codes (>=1)
//  PASSCODE        4'hA  code that disarms
//  MAX_TRIES       3     consecutive wrong codes that cause lockout (1..3)
// PORTS
//  clk         in   1  system clock, rising edge
//  rst         in   1  synchronous, active-high reset
//  walm        in   1  window alarm level from window module, sampled each edge
//  arm         in   1  arm request pulse
//  code        in   4  passcode digit
//  code_valid  in   1  code qualifier, one cycle per entry
//  siren       out  1  siren drive
//  armed       out  1  high in every state except DISARMED
//  intrusion   out  1  sticky: an intrusion occurred since the last arm
//  lockout     out  1  high in LOCKOUT
//  tries       out  2  current consecutive wrong-code count
// BEHAVIOUR
//  Reset: state=DISARMED; siren=armed=intrusion=lockout=0; tries=0; timer=0.
//    Reset wins over every other input, including mid-siren and mid-lockout.
//  All outputs are registered and change one edge after the causing input is sampled.
//  "Good code" = code_valid & code==PASSCODE. "Bad code" = code_valid & code!=PASSCODE.
//  DISARMED: arm -> ARMED; intrusion cleared, tries cleared. walm and codes ignored.
//  ARMED: good code -> DISARMED.
//    Else walm -> TRIGGERED: siren=1, intrusion=1, timer=SIREN_CYCLES.
//    Bad code -> tries+1.
//  TRIGGERED: siren=1; timer decrements each cycle; timer==1 -> SILENCED.
//    Siren is therefore high for exactly SIREN_CYCLES cycles.
//    walm while TRIGGERED reloads timer to SIREN_CYCLES (retrigger). Good code -> DISARMED, siren=0.
//  SILENCED: siren=0, intrusion stays 1. walm -> TRIGGERED with reload. Good code -> DISARMED.
//  Bad code in ARMED/TRIGGERED/SILENCED: tries+1.
//    If tries+1==MAX_TRIES -> LOCKOUT: siren=1, lockout=1, timer=LOCKOUT_CYCLES, tries=0.
//  LOCKOUT: all codes and walm ignored; after LOCKOUT_CYCLES cycles -> SILENCED, lockout=0, siren=0.
//  Good code in any armed state clears tries. Arm is ignored outside DISARMED.
//  intrusion is held after disarm and clears only on the next arm.
//  Priority within one cycle: rst > good code > bad code > walm > timer expiry.
//    Good code + walm in ARMED -> DISARMED, no intrusion.
//    Bad code reaching MAX_TRIES + walm -> LOCKOUT.
//    Good code on the timer-expiry cycle -> DISARMED.
//  tries saturates; it never wraps past MAX_TRIES.
//  Timer width is $clog2(max(SIREN_CYCLES,LOCKOUT_CYCLES)+1). SIREN_CYCLES and LOCKOUT_CYCLES never share the timer concurrently.
// STRUCTURE
//  Shared header smart_home_defs.vh holds:
//    the 3-bit state encodings DISARMED/ARMED/TRIGGERED/SILENCED/LOCKOUT
//    the PASSCODE default, shared with the future door and keypad blocks.
//  One sub-module: cycle_timer (load, load_val, tick -> count, expire).
//    A single instance serves both siren and lockout timing.
//  FSM and the tries counter stay in siren_controller.
// TESTING (bench overrides SIREN_CYCLES=8, LOCKOUT_CYCLES=6, PASSCODE=4'hA, MAX_TRIES=3)
//  1 rst=1 two cycles then arm pulse -> armed=1 next edge; siren=0, intrusion=0, tries=0.
//  2 Armed, walm=1 one cycle -> siren=1 for exactly 8 cycles then 0.
//    intrusion stays 1. Second walm pulse 3 cycles into the siren -> siren lasts 8 more cycles.
//  3 Triggered, code=4'hA valid -> siren=0 and armed=0 next edge, intrusion still 1.
//    Next arm pulse -> intrusion=0.
//  4 Armed, codes 4'h1,4'h2 -> tries=1,2; code 4'h3 -> lockout=1, siren=1 for 6 cycles, tries=0.
//    code=4'hA during lockout is ignored. Then state=SILENCED, armed=1.
//  5 Armed, walm=1 and code=4'hA valid in the same cycle -> armed=0, siren=0, intrusion=0.
//  6 rst=1 mid-siren and again mid-lockout -> all outputs 0 next edge.
//    walm while DISARMED -> siren stays 0.

Source files
------------

// File: rtl/siren_controller_pkg.sv
// Shared definitions for the smart-home alarm chain.
//   state_t          : 3-bit controller state encodings
//   DEFAULT_PASSCODE : disarm code shared with door and keypad blocks
//   max_int          : helper used to size the shared timer
package siren_controller_pkg;

    typedef enum logic [2:0] {
        ST_DISARMED  = 3'd0,
        ST_ARMED     = 3'd1,
        ST_TRIGGERED = 3'd2,
        ST_SILENCED  = 3'd3,
        ST_LOCKOUT   = 3'd4
    } state_t;

    localparam logic [3:0] DEFAULT_PASSCODE = 4'hA;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/siren_controller_if.sv
// Signal bundle between the alarm sources / keypad and the siren controller.
//   walm, arm, code, code_valid : requests into the controller
//   siren, armed, intrusion, lockout, tries : controller status
// master : the side that drives requests (window module, keypad, bench)
// slave  : the siren controller
interface siren_controller_if;
    logic       walm;
    logic       arm;
    logic [3:0] code;
    logic       code_valid;
    logic       siren;
    logic       armed;
    logic       intrusion;
    logic       lockout;
    logic [1:0] tries;

    modport master (
        output walm, arm, code, code_valid,
        input  siren, armed, intrusion, lockout, tries
    );

    modport slave (
        input  walm, arm, code, code_valid,
        output siren, armed, intrusion, lockout, tries
    );
endinterface

// File: rtl/siren_controller_cycle_timer.sv
// Down-counting timer shared by the siren and lockout phases.
//   clk, rst  : clock and synchronous active-high reset
//   i_load    : load i_load_val into the counter (wins over i_tick)
//   i_load_val: value to load
//   i_tick    : decrement by one this cycle
//   o_count   : current count
//   o_expire  : count is 1, i.e. this tick ends the timed phase
module cycle_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_tick,
    output logic [W-1:0] o_count,
    output logic         o_expire
);
    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_tick && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_count  = r_count;
    assign o_expire = (r_count == W'(1));
endmodule

// File: rtl/siren_controller.sv
// Alarm controller downstream of the window module.
// Holds arm state, latches intrusions, runs the siren for a bounded time,
// accepts a passcode to disarm and locks out code entry after repeated
// wrong codes.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of siren_controller_if (requests in, status out)
module siren_controller
    import siren_controller_pkg::*;
#(
    parameter int         SIREN_CYCLES   = 20,
    parameter int         LOCKOUT_CYCLES = 30,
    parameter logic [3:0] PASSCODE       = DEFAULT_PASSCODE,
    parameter int         MAX_TRIES      = 3
) (
    input  logic               clk,
    input  logic               rst,
    siren_controller_if.slave  bus
);
    localparam int TIMER_W = $clog2(max_int(SIREN_CYCLES, LOCKOUT_CYCLES) + 1);

    state_t       r_state;
    logic         r_siren;
    logic         r_armed;
    logic         r_intrusion;
    logic         r_lockout;
    logic [1:0]   r_tries;

    logic         w_good;
    logic         w_bad;
    logic         w_armed_state;
    logic [2:0]   w_tries_inc;
    logic         w_hit_max;
    logic         w_load;
    logic [TIMER_W-1:0] w_load_val;
    logic         w_tick;
    logic [TIMER_W-1:0] w_count;
    logic         w_expire;

    assign w_good        = bus.code_valid && (bus.code == PASSCODE);
    assign w_bad         = bus.code_valid && (bus.code != PASSCODE);
    assign w_armed_state = (r_state == ST_ARMED) || (r_state == ST_TRIGGERED) ||
                           (r_state == ST_SILENCED);
    assign w_tries_inc   = {1'b0, r_tries} + 3'd1;
    // A wrong code that completes the try budget pre-empts walm this cycle.
    assign w_hit_max     = w_armed_state && w_bad && (w_tries_inc >= 3'(MAX_TRIES));

    // Timer control mirrors the state transitions below: lockout entry
    // loads the lockout period, otherwise walm (re)loads the siren period.
    always_comb begin
        w_load     = 1'b0;
        w_load_val = '0;
        if (w_armed_state && !w_good) begin
            if (w_hit_max) begin
                w_load     = 1'b1;
                w_load_val = TIMER_W'(LOCKOUT_CYCLES);
            end else if (bus.walm) begin
                w_load     = 1'b1;
                w_load_val = TIMER_W'(SIREN_CYCLES);
            end
        end
    end

    assign w_tick = ((r_state == ST_TRIGGERED) || (r_state == ST_LOCKOUT)) &&
                    (w_count != '0);

    cycle_timer #(
        .W (TIMER_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_tick     (w_tick),
        .o_count    (w_count),
        .o_expire   (w_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_DISARMED;
            r_siren     <= 1'b0;
            r_armed     <= 1'b0;
            r_intrusion <= 1'b0;
            r_lockout   <= 1'b0;
            r_tries     <= 2'd0;
        end else begin
            case (r_state)
                ST_DISARMED: begin
                    if (bus.arm) begin
                        r_state     <= ST_ARMED;
                        r_armed     <= 1'b1;
                        r_intrusion <= 1'b0;
                        r_tries     <= 2'd0;
                    end
                end

                ST_ARMED, ST_TRIGGERED, ST_SILENCED: begin
                    if (w_good) begin
                        r_state <= ST_DISARMED;
                        r_armed <= 1'b0;
                        r_siren <= 1'b0;
                        r_tries <= 2'd0;
                    end else if (w_hit_max) begin
                        r_state   <= ST_LOCKOUT;
                        r_siren   <= 1'b1;
                        r_lockout <= 1'b1;
                        r_tries   <= 2'd0;
                    end else begin
                        // A wrong code below the limit only counts; walm and
                        // expiry are still handled in the same cycle.
                        if (w_bad && (r_tries != 2'd3)) begin
                            r_tries <= w_tries_inc[1:0];
                        end
                        if (bus.walm) begin
                            r_state     <= ST_TRIGGERED;
                            r_siren     <= 1'b1;
                            r_intrusion <= 1'b1;
                        end else if ((r_state == ST_TRIGGERED) && w_expire) begin
                            r_state <= ST_SILENCED;
                            r_siren <= 1'b0;
                        end
                    end
                end

                ST_LOCKOUT: begin
                    if (w_expire) begin
                        r_state   <= ST_SILENCED;
                        r_siren   <= 1'b0;
                        r_lockout <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_DISARMED;
                    r_siren <= 1'b0;
                    r_armed <= 1'b0;
                    r_lockout <= 1'b0;
                    r_tries <= 2'd0;
                end
            endcase
        end
    end

    assign bus.siren     = r_siren;
    assign bus.armed     = r_armed;
    assign bus.intrusion = r_intrusion;
    assign bus.lockout   = r_lockout;
    assign bus.tries     = r_tries;
endmodule

// File: tb/tb_siren_controller.sv
// Directed bench for siren_controller: a vector table for single-cycle
// behaviour plus hand-written sequences for the timed siren phases.
module tb_siren_controller;

    logic clk;
    logic rst;

    siren_controller_if sif ();

    siren_controller #(
        .SIREN_CYCLES   (8),
        .LOCKOUT_CYCLES (6),
        .PASSCODE       (4'hA),
        .MAX_TRIES      (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst;
        logic       walm;
        logic       arm;
        logic [3:0] code;
        logic       cv;
        logic [5:0] exp;   // {siren, armed, intrusion, lockout, tries}
    } vec_t;

    vec_t vq[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic vec_t mk(input string n, input logic r, input logic w,
                                input logic a, input logic [3:0] c,
                                input logic v, input logic [5:0] e);
        vec_t t;
        t.name = n; t.rst = r; t.walm = w; t.arm = a; t.code = c; t.cv = v; t.exp = e;
        return t;
    endfunction

    // Drive one cycle of inputs, let one edge pass, sample 1 time unit later.
    task automatic step(input logic r, input logic w, input logic a,
                        input logic [3:0] c, input logic v);
        rst = r; sif.walm = w; sif.arm = a; sif.code = c; sif.code_valid = v;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] outs();
        return {sif.siren, sif.armed, sif.intrusion, sif.lockout, sif.tries};
    endfunction

    task automatic check(input string n, input logic [5:0] e);
        logic [5:0] a;
        a = outs();
        n_cmp++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got siren/armed/intr/lock/tries=%b required %b", n, a, e);
        end else begin
            $display("ok   %s: siren/armed/intr/lock/tries=%b", n, a);
        end
    endtask

    task automatic check_int(input string n, input int a, input int e);
        n_cmp++;
        if (a != e) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", n, a, e);
        end else begin
            $display("ok   %s: %0d", n, a);
        end
    endtask

    int hi;

    initial begin
        // name, rst, walm, arm, code, code_valid, {siren,armed,intr,lock,tries}
        vq.push_back(mk("rst0",          1, 0, 0, 4'h0, 0, 6'b0000_00));
        vq.push_back(mk("rst1",          1, 0, 0, 4'h0, 0, 6'b0000_00));
        vq.push_back(mk("arm",           0, 0, 1, 4'h0, 0, 6'b0100_00));
        vq.push_back(mk("armed_idle",    0, 0, 0, 4'h0, 0, 6'b0100_00));
        vq.push_back(mk("trigger",       0, 1, 0, 4'h0, 0, 6'b1110_00));
        vq.push_back(mk("trig_hold",     0, 0, 0, 4'h0, 0, 6'b1110_00));
        vq.push_back(mk("good_in_trig",  0, 0, 0, 4'hA, 1, 6'b0010_00));
        vq.push_back(mk("walm_disarmed", 0, 1, 0, 4'h0, 0, 6'b0010_00));
        vq.push_back(mk("rearm_clr",     0, 0, 1, 4'h0, 0, 6'b0100_00));
        vq.push_back(mk("bad1",          0, 0, 0, 4'h1, 1, 6'b0100_01));
        vq.push_back(mk("bad2",          0, 0, 0, 4'h2, 1, 6'b0100_10));
        vq.push_back(mk("bad3_lockout",  0, 0, 0, 4'h3, 1, 6'b1101_00));
        vq.push_back(mk("lock_good_ign", 0, 0, 0, 4'hA, 1, 6'b1101_00));
        vq.push_back(mk("lock_walm_ign", 0, 1, 0, 4'h0, 0, 6'b1101_00));
        vq.push_back(mk("lock_c3",       0, 0, 0, 4'h0, 0, 6'b1101_00));
        vq.push_back(mk("lock_c4",       0, 0, 0, 4'h0, 0, 6'b1101_00));
        vq.push_back(mk("lock_c5",       0, 0, 0, 4'h0, 0, 6'b1101_00));
        vq.push_back(mk("lock_end",      0, 0, 0, 4'h0, 0, 6'b0100_00));
        vq.push_back(mk("good_silenced", 0, 0, 0, 4'hA, 1, 6'b0000_00));
        vq.push_back(mk("arm2",          0, 0, 1, 4'h0, 0, 6'b0100_00));
        vq.push_back(mk("walm_good",     0, 1, 0, 4'hA, 1, 6'b0000_00));
        vq.push_back(mk("arm3",          0, 0, 1, 4'h0, 0, 6'b0100_00));
        vq.push_back(mk("badA",          0, 0, 0, 4'h5, 1, 6'b0100_01));
        vq.push_back(mk("badB",          0, 0, 0, 4'h6, 1, 6'b0100_10));
        vq.push_back(mk("bad_walm_lock", 0, 1, 0, 4'h7, 1, 6'b1101_00));
        vq.push_back(mk("rst_mid_lock",  1, 0, 0, 4'h0, 0, 6'b0000_00));
        vq.push_back(mk("walm_dis2",     0, 1, 0, 4'h0, 0, 6'b0000_00));
        vq.push_back(mk("arm4",          0, 0, 1, 4'h0, 0, 6'b0100_00));
        vq.push_back(mk("bad_then",      0, 0, 0, 4'h1, 1, 6'b0100_01));
        vq.push_back(mk("good_clr_try",  0, 0, 0, 4'hA, 1, 6'b0000_00));

        foreach (vq[i]) begin
            step(vq[i].rst, vq[i].walm, vq[i].arm, vq[i].code, vq[i].cv);
            check(vq[i].name, vq[i].exp);
        end

        // Single trigger: siren high for exactly 8 sampled cycles.
        step(0, 0, 1, 4'h0, 0);
        step(0, 1, 0, 4'h0, 0);
        hi = 0;
        for (int k = 0; k < 40 && sif.siren === 1'b1; k++) begin
            hi++;
            step(0, 0, 0, 4'h0, 0);
        end
        check_int("siren_len", hi, 8);
        check("after_siren", 6'b0110_00);

        // Retrigger three cycles in: 3 cycles before the reload plus 8 after.
        step(0, 1, 0, 4'h0, 0);
        hi = 1;
        step(0, 0, 0, 4'h0, 0); hi += (sif.siren === 1'b1) ? 1 : 0;
        step(0, 0, 0, 4'h0, 0); hi += (sif.siren === 1'b1) ? 1 : 0;
        step(0, 1, 0, 4'h0, 0);
        for (int k = 0; k < 40 && sif.siren === 1'b1; k++) begin
            hi++;
            step(0, 0, 0, 4'h0, 0);
        end
        check_int("retrig_len", hi, 11);
        check("after_retrig", 6'b0110_00);

        // Reset in the middle of a siren.
        step(0, 1, 0, 4'h0, 0);
        step(0, 0, 0, 4'h0, 0);
        check("mid_siren", 6'b1110_00);
        step(1, 0, 0, 4'h0, 0);
        check("rst_mid_siren", 6'b0000_00);
        step(0, 1, 0, 4'h0, 0);
        check("walm_after_rst", 6'b0000_00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
